// File: rtl/ecc_14_bist_pkg.sv
// Shared types and constants for the 14-bit ECC checker BIST sequencer.
package ecc_14_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    localparam int STEPS_PER_BASE = 41;
    localparam int NUM_BASES      = 4;
    localparam int CW_W           = 20;
    localparam int TOTAL_STEPS    = STEPS_PER_BASE * NUM_BASES;

    // Entry [0] is the first base exercised.
    localparam logic [NUM_BASES-1:0][13:0] BASE_WORDS = {
        14'h1555, 14'h2AAA, 14'h3FFF, 14'h0000
    };

endpackage

// File: rtl/ecc_14_bist_pat_gen.sv
// Combinational BIST pattern generator: (base index, step within base) -> base word,
// codeword flip mask and the checker response expected for that vector.
module ecc_14_bist_pat_gen
    import ecc_14_bist_pkg::*;
(
    input  logic [1:0]      base_idx,
    input  logic [5:0]      step_k,
    output logic [13:0]     base_word,
    output logic [CW_W-1:0] flip_mask,
    output logic            exp_sbit,
    output logic            exp_dbit,
    output logic            exp_data_chk
);

    logic [5:0] lo_bit;
    logic [5:0] hi_bit;

    always_comb begin
        base_word    = BASE_WORDS[base_idx];
        flip_mask    = '0;
        exp_sbit     = 1'b0;
        exp_dbit     = 1'b0;
        exp_data_chk = 1'b1;
        lo_bit       = step_k - 6'd21;
        hi_bit       = (lo_bit == 6'd19) ? 6'd0 : lo_bit + 6'd1;

        if (step_k == 6'd0) begin
            flip_mask = '0;
        end else if (step_k <= 6'd20) begin
            flip_mask = CW_W'(1) << (step_k - 6'd1);
            exp_sbit  = 1'b1;
        end else begin
            // Adjacent pair, wrapping the last bit back onto bit 0.
            flip_mask    = (CW_W'(1) << lo_bit) | (CW_W'(1) << hi_bit);
            exp_dbit     = 1'b1;
            exp_data_chk = 1'b0;
        end
    end

endmodule

// File: rtl/ecc_14_bist_ctrl.sv
// BIST sequencer sharing the ECC checker port with functional traffic (functional has priority).
// Optional build macro ECC_BIST_STOP_ON_FAIL_EN ends the sequence on the first mismatch.
module ecc_14_bist_ctrl
    import ecc_14_bist_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int PARITY_WIDTH = 6,
    parameter int CHK_LAT      = 1,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bist_start,
    input  logic                    bist_abort,
    input  logic                    func_valid,
    input  logic [DATA_WIDTH-1:0]   func_data,
    input  logic [PARITY_WIDTH-1:0] func_parity,
    output logic [DATA_WIDTH-1:0]   enc_data,
    input  logic [PARITY_WIDTH-1:0] enc_parity,
    output logic                    chk_valid,
    output logic [DATA_WIDTH-1:0]   chk_data,
    output logic [PARITY_WIDTH-1:0] chk_parity,
    input  logic [DATA_WIDTH-1:0]   chk_data_out,
    input  logic                    chk_sbit_err,
    input  logic                    chk_dbit_err,
    input  logic                    chk_ecc_fault,
    output logic                    bist_busy,
    output logic                    bist_done,
    output logic                    bist_pass,
    output logic [CNT_W-1:0]        bist_fail_step,
    output logic [CNT_W-1:0]        bist_fail_cnt
);

    localparam int               LAT_W     = (CHK_LAT < 2) ? 1 : $clog2(CHK_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(TOTAL_STEPS - 1);
    localparam logic [5:0]       LAST_K    = 6'(STEPS_PER_BASE - 1);

    bist_state_e           state_q, state_d;
    logic [CNT_W-1:0]      step_q, step_d;
    logic [5:0]            k_q, k_d;
    logic [1:0]            base_q, base_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  cap_sbit_q, cap_sbit_d;
    logic                  cap_dbit_q, cap_dbit_d;
    logic                  cap_fault_q, cap_fault_d;
    logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic                  pass_q, pass_d;
    logic [CNT_W-1:0]      fail_step_q, fail_step_d;
    logic [CNT_W-1:0]      fail_cnt_q, fail_cnt_d;

    logic [13:0]           base_word;
    logic [CW_W-1:0]       flip_mask;
    logic                  exp_sbit, exp_dbit, exp_data_chk;
    logic [CW_W-1:0]       bist_cw;

    logic                  obs_sbit, obs_dbit, obs_fault;
    logic [DATA_WIDTH-1:0] obs_data;
    logic                  mismatch;
    logic                  do_check;
    logic                  stop;

    ecc_14_bist_pat_gen u_pat_gen (
        .base_idx     (base_q),
        .step_k       (k_q),
        .base_word    (base_word),
        .flip_mask    (flip_mask),
        .exp_sbit     (exp_sbit),
        .exp_dbit     (exp_dbit),
        .exp_data_chk (exp_data_chk)
    );

    assign enc_data = base_word;
    assign bist_cw  = {enc_parity, base_word} ^ flip_mask;

    always_comb begin
        chk_valid  = 1'b0;
        chk_data   = '0;
        chk_parity = '0;
        if (func_valid) begin
            chk_valid  = 1'b1;
            chk_data   = func_data;
            chk_parity = func_parity;
        end else if (state_q == ST_ISSUE) begin
            chk_valid  = 1'b1;
            chk_data   = bist_cw[DATA_WIDTH-1:0];
            chk_parity = bist_cw[CW_W-1:DATA_WIDTH];
        end
    end

    // Zero latency compares the live checker response in the issue cycle.
    always_comb begin
        if (CHK_LAT == 0) begin
            obs_sbit  = chk_sbit_err;
            obs_dbit  = chk_dbit_err;
            obs_fault = chk_ecc_fault;
            obs_data  = chk_data_out;
        end else begin
            obs_sbit  = cap_sbit_q;
            obs_dbit  = cap_dbit_q;
            obs_fault = cap_fault_q;
            obs_data  = cap_data_q;
        end
        mismatch = obs_fault
                 | (obs_sbit != exp_sbit)
                 | (obs_dbit != exp_dbit)
                 | (exp_data_chk && (obs_data != base_word));
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        k_d         = k_q;
        base_d      = base_q;
        lat_d       = lat_q;
        cap_sbit_d  = cap_sbit_q;
        cap_dbit_d  = cap_dbit_q;
        cap_fault_d = cap_fault_q;
        cap_data_d  = cap_data_q;
        pass_d      = pass_q;
        fail_step_d = fail_step_q;
        fail_cnt_d  = fail_cnt_q;
        do_check    = 1'b0;
        stop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bist_start) begin
                    state_d     = ST_ISSUE;
                    step_d      = '0;
                    k_d         = '0;
                    base_d      = '0;
                    pass_d      = 1'b1;
                    fail_step_d = '0;
                    fail_cnt_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (!func_valid) begin
                    if (CHK_LAT == 0) begin
                        do_check = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_W'(CHK_LAT);
                    end
                end
            end
            ST_WAIT: begin
                // Sample exactly CHK_LAT cycles after issue; the checker carries no tag.
                if (lat_q <= LAT_W'(1)) begin
                    cap_sbit_d  = chk_sbit_err;
                    cap_dbit_d  = chk_dbit_err;
                    cap_fault_d = chk_ecc_fault;
                    cap_data_d  = chk_data_out;
                    state_d     = ST_CHECK;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_CHECK: do_check = 1'b1;
            ST_DONE:  state_d  = ST_IDLE;
            default:  state_d  = ST_IDLE;
        endcase

        if (do_check) begin
            if (mismatch) begin
                if (fail_cnt_q != '1) begin
                    fail_cnt_d = fail_cnt_q + CNT_W'(1);
                end
                pass_d = 1'b0;
                if (pass_q) begin
                    fail_step_d = step_q;
                end
`ifdef ECC_BIST_STOP_ON_FAIL_EN
                stop = 1'b1;
`else
                stop = 1'b0;
`endif
            end
            if (stop || (step_q == LAST_STEP)) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_ISSUE;
                step_d  = step_q + CNT_W'(1);
                if (k_q == LAST_K) begin
                    k_d    = '0;
                    base_d = base_q + 2'd1;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
        end

        // Abort drops any in-flight check and leaves the results untouched.
        if (bist_abort) begin
            state_d     = ST_IDLE;
            pass_d      = pass_q;
            fail_step_d = fail_step_q;
            fail_cnt_d  = fail_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            k_q         <= '0;
            base_q      <= '0;
            lat_q       <= '0;
            cap_sbit_q  <= 1'b0;
            cap_dbit_q  <= 1'b0;
            cap_fault_q <= 1'b0;
            cap_data_q  <= '0;
            pass_q      <= 1'b0;
            fail_step_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            k_q         <= k_d;
            base_q      <= base_d;
            lat_q       <= lat_d;
            cap_sbit_q  <= cap_sbit_d;
            cap_dbit_q  <= cap_dbit_d;
            cap_fault_q <= cap_fault_d;
            cap_data_q  <= cap_data_d;
            pass_q      <= pass_d;
            fail_step_q <= fail_step_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign bist_busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign bist_done      = (state_q == ST_DONE);
    assign bist_pass      = pass_q;
    assign bist_fail_step = fail_step_q;
    assign bist_fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_ecc_14_bist_ctrl.sv
// Randomized bench for ecc_14_bist_ctrl with a behavioural SECDED checker and result model.
module tb_ecc_14_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bist_start, bist_abort;
    logic        func_valid;
    logic [13:0] func_data;
    logic [5:0]  func_parity;
    logic [13:0] enc_data;
    logic [5:0]  enc_parity;
    logic        chk_valid;
    logic [13:0] chk_data;
    logic [5:0]  chk_parity;
    logic [13:0] chk_data_out;
    logic        chk_sbit_err, chk_dbit_err, chk_ecc_fault;
    logic        bist_busy, bist_done, bist_pass;
    logic [7:0]  bist_fail_step, bist_fail_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ecc_14_bist_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .bist_start     (bist_start),
        .bist_abort     (bist_abort),
        .func_valid     (func_valid),
        .func_data      (func_data),
        .func_parity    (func_parity),
        .enc_data       (enc_data),
        .enc_parity     (enc_parity),
        .chk_valid      (chk_valid),
        .chk_data       (chk_data),
        .chk_parity     (chk_parity),
        .chk_data_out   (chk_data_out),
        .chk_sbit_err   (chk_sbit_err),
        .chk_dbit_err   (chk_dbit_err),
        .chk_ecc_fault  (chk_ecc_fault),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_pass      (bist_pass),
        .bist_fail_step (bist_fail_step),
        .bist_fail_cnt  (bist_fail_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hamming position (1..19, non powers of two) for data bit i.
    function automatic int dpos(input int i);
        int p = 0;
        int n = -1;
        for (int q = 1; q < 20; q++) begin
            if ((q & (q - 1)) != 0) begin
                n++;
                if (n == i) p = q;
            end
        end
        return p;
    endfunction

    function automatic logic [4:0] syn_of_data(input logic [13:0] d);
        logic [4:0] s = '0;
        for (int i = 0; i < 14; i++) if (d[i]) s ^= 5'(dpos(i));
        return s;
    endfunction

    function automatic logic [5:0] secded_enc(input logic [13:0] d);
        logic [4:0] p = syn_of_data(d);
        return {(^d) ^ (^p), p};
    endfunction

    function automatic void secded_dec(input logic [19:0] cw, output logic s, output logic d,
                                       output logic [13:0] data);
        logic [4:0] syn;
        data = cw[13:0];
        s    = 1'b0;
        d    = 1'b0;
        syn  = syn_of_data(cw[13:0]) ^ cw[18:14];
        if (^cw) begin
            s = 1'b1;
            for (int i = 0; i < 14; i++) if (5'(dpos(i)) == syn) data[i] = ~data[i];
        end else if (syn != 5'd0) begin
            d = 1'b1;
        end
    endfunction

    function automatic logic [19:0] exp_vector(input int idx);
        logic [13:0] b;
        logic [19:0] cw;
        int k;
        case (idx / 41)
            0:       b = 14'h0000;
            1:       b = 14'h3FFF;
            2:       b = 14'h2AAA;
            default: b = 14'h1555;
        endcase
        k  = idx % 41;
        cw = {secded_enc(b), b};
        if (k >= 1 && k <= 20) begin
            cw[k-1] = ~cw[k-1];
        end else if (k >= 21) begin
            cw[k-21]         = ~cw[k-21];
            cw[(k-20) % 20]  = ~cw[(k-20) % 20];
        end
        return cw;
    endfunction

    // Checker model: one-cycle registered SECDED decoder with fault injection per BIST issue.
    logic [163:0] fault_mask;
    logic         force_fault;
    int           bist_idx;
    logic         nx_sbit, nx_dbit;
    logic [13:0]  nx_data;

    always_comb enc_parity = secded_enc(enc_data);
    assign chk_ecc_fault = force_fault;

    always @(negedge clk) begin
        if (bist_start) bist_idx = 0;
        nx_sbit = 1'b0;
        nx_dbit = 1'b0;
        nx_data = '0;
        if (chk_valid) begin
            secded_dec({chk_parity, chk_data}, nx_sbit, nx_dbit, nx_data);
            if (!func_valid) begin
                check_eq("bist_vec", 32'({chk_parity, chk_data}), 32'(exp_vector(bist_idx)));
                if (bist_idx < 164 && fault_mask[bist_idx]) nx_sbit = ~nx_sbit;
                bist_idx++;
            end
        end
    end

    always @(posedge clk) begin
        chk_sbit_err <= nx_sbit;
        chk_dbit_err <= nx_dbit;
        chk_data_out <= nx_data;
    end

    task automatic run_bist(input int stall_at, input int abort_at,
                            input logic [163:0] fmask, input logic ffault);
        int nf, first, steps, exp_busy, busy_cnt, done_cnt;
        fault_mask  = fmask;
        force_fault = ffault;
        nf = 0;
        first = -1;
        for (int i = 0; i < 164; i++) begin
            if (ffault || fmask[i]) begin
                nf++;
                if (first < 0) first = i;
            end
        end
        steps = 164;
`ifdef ECC_BIST_STOP_ON_FAIL_EN
        if (nf > 0) begin
            steps = first + 1;
            nf    = 1;
        end
`endif
        exp_busy = steps * 3 + ((stall_at > 0) ? 10 : 0);
        busy_cnt = 0;
        done_cnt = 0;

        @(posedge clk); #1 bist_start = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            bist_start  = 1'b0;
            bist_abort  = (c == abort_at);
            func_valid  = (stall_at > 0 && c >= stall_at && c < stall_at + 10);
            func_data   = 14'($urandom);
            func_parity = 6'($urandom);
            @(negedge clk);
            if (bist_busy) busy_cnt++;
            if (bist_done) done_cnt++;
            if (func_valid) begin
                check_eq("func_valid_pass", 32'(chk_valid), 32'd1);
                check_eq("func_data_pass", 32'({chk_parity, chk_data}), 32'({func_parity, func_data}));
            end
            if (abort_at > 0 && c == abort_at + 1) check_eq("abort_busy", 32'(bist_busy), 32'd0);
            if (abort_at > 0 && c == abort_at + 20) break;
            if (done_cnt > 0 && !bist_done) break;
        end
        bist_abort = 1'b0;
        func_valid = 1'b0;

        if (abort_at > 0) begin
            check_eq("abort_no_done", 32'(done_cnt), 32'd0);
            check_eq("abort_pass_kept", 32'(bist_pass), 32'd1);
        end else begin
            check_eq("done_pulses", 32'(done_cnt), 32'd1);
            check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
            check_eq("busy_after_done", 32'(bist_busy), 32'd0);
            check_eq("pass", 32'(bist_pass), 32'(nf == 0));
            check_eq("fail_cnt", 32'(bist_fail_cnt), 32'(nf));
            check_eq("fail_step", 32'(bist_fail_step), 32'((first < 0) ? 0 : first));
        end
    endtask

    initial begin
        logic [163:0] m;
        rst = 1'b1;
        bist_start = 1'b0; bist_abort = 1'b0;
        func_valid = 1'b0; func_data = '0; func_parity = '0;
        fault_mask = '0; force_fault = 1'b0; bist_idx = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(bist_busy), 32'd0);
        check_eq("rst_done", 32'(bist_done), 32'd0);
        check_eq("rst_pass", 32'(bist_pass), 32'd0);
        check_eq("rst_fail_step", 32'(bist_fail_step), 32'd0);
        check_eq("rst_fail_cnt", 32'(bist_fail_cnt), 32'd0);
        check_eq("rst_chk_valid", 32'(chk_valid), 32'd0);
        check_eq("rst_chk_word", 32'({chk_parity, chk_data}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_bist(0, 0, '0, 1'b0);

        m = '0; m[5] = 1'b1;
        run_bist(0, 0, m, 1'b0);

        m = '0;
        for (int i = 0; i < 3; i++) m[$urandom_range(0, 163)] = 1'b1;
        run_bist(0, 0, m, 1'b0);

        run_bist(1 + 3 * $urandom_range(5, 150), 0, '0, 1'b0);

        run_bist(0, 0, '0, 1'b1);
        force_fault = 1'b0;

        // Start and abort together: abort wins.
        @(posedge clk); #1 bist_start = 1'b1; bist_abort = 1'b1;
        @(posedge clk); #1 bist_start = 1'b0; bist_abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_busy", 32'(bist_busy), 32'd0);

        run_bist(0, 1 + 3 * 50, '0, 1'b0);
        run_bist(0, 0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
